fpu_ss_hazard_unit: RTL and testbench
=====================================

# fpu_ss_hazard_unit

Parametrised hazard, commit and writeback tracker for the FPU subsystem. It replaces the single-bit register and ID scoreboards with per-register outstanding-write counters, so RAW is tracked and WAW-stalled only on counter saturation. It supports N writeback ports, tracks commit and kill per ID, and drops killed instructions. It sits between the instruction buffer pop side and the FPnew/LSU issue logic.

## Interface
- NUM_REGS, 32, number of tracked FP registers; RW = $clog2(NUM_REGS)
- ID_WIDTH, 4, offload ID width; NUM_IDS = 2**ID_WIDTH
- CNT_WIDTH, 2, width of per-register outstanding-write counter; max = 2**CNT_WIDTH-1
- NUM_WB, 2, number of writeback ports (port 0 = FPnew, 1 = LSU by convention)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- issue_valid_i  in  1  buffer head valid
- issue_ready_o  out  1  head may leave buffer this cycle (issued or dropped)
- issue_id_i  in  ID_WIDTH  head offload ID
- issue_rs_i  in  3*RW  source regs rs1..rs3
- issue_rs_used_i  in  3  operand j reads FP reg
- issue_rd_i  in  RW  destination reg
- issue_rd_fp_i  in  1  destination is FP reg
- issue_fire_o  out  1  instruction dispatched (counted)
- drop_o  out  1  head discarded because killed
- commit_valid_i  in  1  commit strobe
- commit_id_i  in  ID_WIDTH  committed ID
- commit_kill_i  in  1  1 = kill, 0 = commit
- wb_valid_i  in  NUM_WB  writeback valid per port
- wb_we_i  in  NUM_WB  writeback targets FP reg
- wb_rd_i  in  NUM_WB*RW  writeback register per port
- fwd_en_o  out  3  operand j taken from a writeback port
- fwd_sel_o  out  3*$clog2(NUM_WB)  port index per operand (0 if NUM_WB==1)
- busy_o  out  1  any counter nonzero
- err_o  out  1  sticky: counter underflow or overflow

## Operation
- State: cnt[NUM_REGS] of CNT_WIDTH; committed[NUM_IDS]; killed[NUM_IDS]; err flag.
- Commit: commit_valid_i & ~commit_kill_i sets committed[id]; with kill sets killed[id]. Same-cycle commit of issue_id_i counts as committed (bypass).
- Head resolution, in priority order:
  - killed[issue_id_i] or a same-cycle kill for it -> drop_o=1 and issue_ready_o=1; no counter change; clear killed and committed for that ID.
  - Not committed -> stall.
  - RAW: for each used operand j, cnt[rs_j]!=0 stalls unless forwardable.
  - WAW: issue_rd_fp_i & cnt[rd]==max stalls, unless a same-cycle writeback to rd decrements it.
  - Otherwise issue_fire_o=1 and issue_ready_o=1; committed[id] is cleared.
- Forwardable: cnt[rs_j]==1 and some port p has wb_valid & wb_we & wb_rd==rs_j. The lowest such p wins and drives fwd_sel_o[j], fwd_en_o[j]=1.
- Counter update per register:
  - Next value = cnt + (fire & rd_fp & rd==r) − (number of ports writing back r).
  - Simultaneous increment and decrement on the same register nets out.
  - Multiple ports writing back the same register in one cycle are all counted.
- Underflow (decrement below 0) or overflow: saturate, set err_o; cleared only by reset.
- All outputs are gated by issue_valid_i, except busy_o and err_o.

## Timing
- Reset: all counters 0, committed and killed 0; every output 0.
- issue_ready_o, issue_fire_o, drop_o, fwd_* are combinational from state plus same-cycle commit and wb inputs. State updates on posedge clk_i.
- Latencies:
  - A writeback in cycle t frees its register for issue in cycle t via forwarding, or from t+1 via the counter.
  - A commit in cycle t enables issue in t.
- Reset asserted mid-operation clears all tracking immediately (async); no pending writeback is remembered.
- issue_valid_i=0: no state change from the issue side; commit and wb updates still apply.

## Configuration
- FPU_SS_HAZARD_FWD_EN defined: forwarding as above.
- Undefined: fwd_en_o and fwd_sel_o are tied 0; any cnt[rs_j]!=0 stalls; the counter and commit logic are unchanged.

## Test plan
- Commit id 3, then issue id 3 with rd=f5 -> fire in the issue cycle; cnt[5]=1; busy_o=1.
- cnt[5]=1, head reads rs1=f5, wb port 1 writes f5 in the same cycle -> with FWD_EN: fire, fwd_en_o=001, fwd_sel_o[0]=1; without: stall one cycle, fire next.
- Three issues to rd=f2 with CNT_WIDTH=2 -> cnt=3. A fourth issue stalls until any wb to f2, then fires in the same cycle as that wb; cnt stays 3.
- Kill id 7 and present head id 7 -> drop_o=1, issue_fire_o=0; no counter change.
- wb to f9 with cnt[9]=0 -> err_o=1 sticky; cnt stays 0. Assert rst_ni low -> err_o=0.
- Ports 0 and 1 both write back f4 with cnt[4]=2 -> cnt[4]=0 the next cycle; busy_o=0 if no other register is pending.

Source files
------------

// File: rtl/fpu_ss_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fpu_ss_hazard_unit
// Brief    : Counter-based RAW/WAW hazard, commit/kill and writeback tracker.
//            Define FPU_SS_HAZARD_FWD_EN to enable writeback-to-operand forwarding.
// Revision : 1.0
// ============================================================================
module fpu_ss_hazard_unit #(
   parameter int NUM_REGS  = 32,
   parameter int ID_WIDTH  = 4,
   parameter int CNT_WIDTH = 2,
   parameter int NUM_WB    = 2,
   localparam int RW       = $clog2(NUM_REGS),
   localparam int SW       = (NUM_WB > 1) ? $clog2(NUM_WB) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  issue_valid_i,
   output logic                  issue_ready_o,
   input  logic [ID_WIDTH-1:0]   issue_id_i,
   input  logic [3*RW-1:0]       issue_rs_i,
   input  logic [2:0]            issue_rs_used_i,
   input  logic [RW-1:0]         issue_rd_i,
   input  logic                  issue_rd_fp_i,
   output logic                  issue_fire_o,
   output logic                  drop_o,
   input  logic                  commit_valid_i,
   input  logic [ID_WIDTH-1:0]   commit_id_i,
   input  logic                  commit_kill_i,
   input  logic [NUM_WB-1:0]     wb_valid_i,
   input  logic [NUM_WB-1:0]     wb_we_i,
   input  logic [NUM_WB*RW-1:0]  wb_rd_i,
   output logic [2:0]            fwd_en_o,
   output logic [3*SW-1:0]       fwd_sel_o,
   output logic                  busy_o,
   output logic                  err_o
);
   localparam int                   NUM_IDS   = 2**ID_WIDTH;
   localparam int                   c_DW      = $clog2(NUM_WB + 1);
   localparam int                   c_EW      = CNT_WIDTH + c_DW + 1;
   localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

   logic [CNT_WIDTH-1:0] r_cnt [NUM_REGS];
   logic [NUM_IDS-1:0]   r_committed;
   logic [NUM_IDS-1:0]   r_killed;
   logic                 r_err;

   logic [c_DW-1:0]      w_dec     [NUM_REGS];
   logic [CNT_WIDTH-1:0] w_cnt_nxt [NUM_REGS];
   logic [NUM_REGS-1:0]  w_sat;
   logic [c_EW-1:0]      w_sum;
   logic [2:0]           w_fwd_ok;
   logic [2:0]           w_raw;
   logic [3*SW-1:0]      w_sel;
   logic                 w_kill_hit;
   logic                 w_commit_hit;
   logic                 w_waw;
   logic                 w_drop;
   logic                 w_fire;
   logic                 w_busy;

   // Number of writeback ports retiring each register this cycle
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         w_dec[r] = '0;
         for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid_i[p] && wb_we_i[p] && (wb_rd_i[p*RW +: RW] == RW'(r)))
               w_dec[r] = w_dec[r] + c_DW'(1);
         end
      end
   end

   always_comb begin
      w_fwd_ok = '0;
      w_sel    = '0;
      w_raw    = '0;
      for (int j = 0; j < 3; j++) begin
`ifdef FPU_SS_HAZARD_FWD_EN
         if (r_cnt[issue_rs_i[j*RW +: RW]] == CNT_WIDTH'(1)) begin
            for (int p = 0; p < NUM_WB; p++) begin
               if (!w_fwd_ok[j] && wb_valid_i[p] && wb_we_i[p] &&
                   (wb_rd_i[p*RW +: RW] == issue_rs_i[j*RW +: RW])) begin
                  w_fwd_ok[j]       = 1'b1;
                  w_sel[j*SW +: SW] = SW'(p);
               end
            end
         end
`endif
         w_raw[j] = issue_rs_used_i[j] && (r_cnt[issue_rs_i[j*RW +: RW]] != '0) && !w_fwd_ok[j];
      end
   end

   assign w_kill_hit   = commit_valid_i && commit_kill_i && (commit_id_i == issue_id_i);
   assign w_commit_hit = commit_valid_i && !commit_kill_i && (commit_id_i == issue_id_i);
   assign w_waw        = issue_rd_fp_i && (r_cnt[issue_rd_i] == c_CNT_MAX) && (w_dec[issue_rd_i] == '0);
   assign w_drop       = issue_valid_i && (r_killed[issue_id_i] || w_kill_hit);
   assign w_fire       = issue_valid_i && !(r_killed[issue_id_i] || w_kill_hit) &&
                         (r_committed[issue_id_i] || w_commit_hit) && !(|w_raw) && !w_waw;

   // Increment and decrement net out; anything leaving the range saturates and flags
   always_comb begin
      w_sat = '0;
      w_sum = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         w_sum = c_EW'(r_cnt[r]) + c_EW'(w_fire && issue_rd_fp_i && (issue_rd_i == RW'(r)));
         if (w_sum < c_EW'(w_dec[r])) begin
            w_cnt_nxt[r] = '0;
            w_sat[r]     = 1'b1;
         end else if ((w_sum - c_EW'(w_dec[r])) > c_EW'(c_CNT_MAX)) begin
            w_cnt_nxt[r] = c_CNT_MAX;
            w_sat[r]     = 1'b1;
         end else begin
            w_cnt_nxt[r] = CNT_WIDTH'(w_sum - c_EW'(w_dec[r]));
         end
      end
   end

   always_comb begin
      w_busy = 1'b0;
      for (int r = 0; r < NUM_REGS; r++)
         w_busy = w_busy | (r_cnt[r] != '0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int r = 0; r < NUM_REGS; r++)
            r_cnt[r] <= '0;
         r_committed <= '0;
         r_killed    <= '0;
         r_err       <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++)
            r_cnt[r] <= w_cnt_nxt[r];
         if (|w_sat)
            r_err <= 1'b1;
         if (commit_valid_i) begin
            if (commit_kill_i)
               r_killed[commit_id_i] <= 1'b1;
            else
               r_committed[commit_id_i] <= 1'b1;
         end
         // Leaving the head consumes the ID, overriding any same-cycle set
         if (w_drop || w_fire)
            r_committed[issue_id_i] <= 1'b0;
         if (w_drop)
            r_killed[issue_id_i] <= 1'b0;
      end
   end

   assign issue_fire_o  = w_fire;
   assign drop_o        = w_drop;
   assign issue_ready_o = w_fire || w_drop;
   assign fwd_en_o      = issue_valid_i ? (w_fwd_ok & issue_rs_used_i) : 3'b000;
   assign fwd_sel_o     = issue_valid_i ? w_sel : '0;
   assign busy_o        = w_busy;
   assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fpu_ss_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_ss_hazard_unit
// Brief    : Directed and randomized checks of fpu_ss_hazard_unit against a
//            behavioural model (follows FPU_SS_HAZARD_FWD_EN when defined).
// Revision : 1.0
// ============================================================================
module tb_fpu_ss_hazard_unit;
   localparam int NUM_REGS = 32;
   localparam int ID_WIDTH = 4;
   localparam int NUM_IDS  = 16;
   localparam int RW       = 5;
   localparam int SW       = 1;
   localparam int CMAX     = 3;
`ifdef FPU_SS_HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic                clk_i = 1'b0;
   logic                rst_ni = 1'b0;
   logic                issue_valid_i;
   logic                issue_ready_o;
   logic [ID_WIDTH-1:0] issue_id_i;
   logic [3*RW-1:0]     issue_rs_i;
   logic [2:0]          issue_rs_used_i;
   logic [RW-1:0]       issue_rd_i;
   logic                issue_rd_fp_i;
   logic                issue_fire_o;
   logic                drop_o;
   logic                commit_valid_i;
   logic [ID_WIDTH-1:0] commit_id_i;
   logic                commit_kill_i;
   logic [1:0]          wb_valid_i;
   logic [1:0]          wb_we_i;
   logic [2*RW-1:0]     wb_rd_i;
   logic [2:0]          fwd_en_o;
   logic [3*SW-1:0]     fwd_sel_o;
   logic                busy_o;
   logic                err_o;

   fpu_ss_hazard_unit dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_id_i(issue_id_i), .issue_rs_i(issue_rs_i),
      .issue_rs_used_i(issue_rs_used_i), .issue_rd_i(issue_rd_i),
      .issue_rd_fp_i(issue_rd_fp_i), .issue_fire_o(issue_fire_o), .drop_o(drop_o),
      .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
      .commit_kill_i(commit_kill_i), .wb_valid_i(wb_valid_i), .wb_we_i(wb_we_i),
      .wb_rd_i(wb_rd_i), .fwd_en_o(fwd_en_o), .fwd_sel_o(fwd_sel_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: outstanding writes per register, commit/kill marks per ID
   int m_cnt [NUM_REGS];
   bit m_com [NUM_IDS];
   bit m_kill[NUM_IDS];
   bit m_err;
   bit e_fire, e_drop;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int nwb(input int r);
      int n = 0;
      for (int p = 0; p < 2; p++)
         if (wb_valid_i[p] && wb_we_i[p] && int'(wb_rd_i[p*RW +: RW]) == r) n++;
      return n;
   endfunction

   task automatic drive(input bit v, input int id, input int rs0, input int rs1, input int rs2,
                        input bit [2:0] used, input int rd, input bit rdfp,
                        input bit cv, input int cid, input bit ck,
                        input bit [1:0] wbv, input bit [1:0] wbwe, input int w0, input int w1);
      issue_valid_i   = v;
      issue_id_i      = ID_WIDTH'(id);
      issue_rs_i      = {RW'(rs2), RW'(rs1), RW'(rs0)};
      issue_rs_used_i = used;
      issue_rd_i      = RW'(rd);
      issue_rd_fp_i   = rdfp;
      commit_valid_i  = cv;
      commit_id_i     = ID_WIDTH'(cid);
      commit_kill_i   = ck;
      wb_valid_i      = wbv;
      wb_we_i         = wbwe;
      wb_rd_i         = {RW'(w1), RW'(w0)};
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
   endtask

   // Settle inputs, predict outputs from the model, compare
   task automatic eval();
      int  id;
      int  rs;
      bit  kill_eff, com_eff, stall, busy;
      bit  [2:0] e_fwd;
      int  e_sel[3];
      #1;
      id       = int'(issue_id_i);
      kill_eff = m_kill[id] || (commit_valid_i && commit_kill_i && int'(commit_id_i) == id);
      com_eff  = m_com[id]  || (commit_valid_i && !commit_kill_i && int'(commit_id_i) == id);
      stall    = 1'b0;
      for (int j = 0; j < 3; j++) begin
         rs       = int'(issue_rs_i[j*RW +: RW]);
         e_fwd[j] = 1'b0;
         e_sel[j] = 0;
         if (FWD && m_cnt[rs] == 1)
            for (int p = 0; p < 2; p++)
               if (!e_fwd[j] && wb_valid_i[p] && wb_we_i[p] && int'(wb_rd_i[p*RW +: RW]) == rs) begin
                  e_fwd[j] = 1'b1;
                  e_sel[j] = p;
               end
         if (issue_rs_used_i[j] && m_cnt[rs] != 0 && !e_fwd[j]) stall = 1'b1;
         e_fwd[j] = e_fwd[j] && issue_rs_used_i[j] && issue_valid_i;
      end
      if (issue_rd_fp_i && m_cnt[int'(issue_rd_i)] == CMAX && nwb(int'(issue_rd_i)) == 0) stall = 1'b1;
      e_drop = issue_valid_i && kill_eff;
      e_fire = issue_valid_i && !kill_eff && com_eff && !stall;
      busy   = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) if (m_cnt[r] != 0) busy = 1'b1;
      chk("fire",   issue_fire_o,  e_fire);
      chk("drop",   drop_o,        e_drop);
      chk("ready",  issue_ready_o, e_fire || e_drop);
      chk("fwd_en", fwd_en_o,      e_fwd);
      for (int j = 0; j < 3; j++)
         if (e_fwd[j]) chk("fwd_sel", fwd_sel_o[j*SW +: SW], e_sel[j]);
      chk("busy",   busy_o,        busy);
      chk("err",    err_o,         m_err);
   endtask

   task automatic tick();
      int n;
      int id;
      @(posedge clk_i);
      id = int'(issue_id_i);
      for (int r = 0; r < NUM_REGS; r++) begin
         n = m_cnt[r] + ((e_fire && issue_rd_fp_i && int'(issue_rd_i) == r) ? 1 : 0) - nwb(r);
         if (n < 0)         begin n = 0;    m_err = 1'b1; end
         else if (n > CMAX) begin n = CMAX; m_err = 1'b1; end
         m_cnt[r] = n;
      end
      if (commit_valid_i) begin
         if (commit_kill_i) m_kill[int'(commit_id_i)] = 1'b1;
         else               m_com[int'(commit_id_i)]  = 1'b1;
      end
      if (e_drop || e_fire) m_com[id] = 1'b0;
      if (e_drop)           m_kill[id] = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      idle();
      rst_ni = 1'b0;
      #1;
      for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 0;
      for (int i = 0; i < NUM_IDS; i++) begin m_com[i] = 1'b0; m_kill[i] = 1'b0; end
      m_err = 1'b0;
      chk("rst_ready", issue_ready_o, 1'b0);
      chk("rst_fire",  issue_fire_o,  1'b0);
      chk("rst_drop",  drop_o,        1'b0);
      chk("rst_fwd",   {fwd_en_o, fwd_sel_o}, 0);
      chk("rst_busy",  busy_o,        1'b0);
      chk("rst_err",   err_o,         1'b0);
      #1;
      rst_ni = 1'b1;
   endtask

   initial begin
      bit  [1:0] wbv, wbwe;
      int  wr[2];
      int  off, id;
      do_reset();

      // Commit first, then issue
      drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 1, 3, 0, 2'b00, 2'b00, 0, 0); eval(); tick();
      drive(1, 3, 0, 0, 0, 3'b000, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0); eval();
      chk("tp_issue_fire", issue_fire_o, 1'b1);
      tick();
      chk("tp_busy_set", busy_o, 1'b1);

      // RAW on f5 with same-cycle writeback on port 1, then retry
      drive(1, 4, 5, 0, 0, 3'b001, 6, 0, 1, 4, 0, 2'b10, 2'b10, 0, 5); eval(); tick();
      drive(1, 4, 5, 0, 0, 3'b001, 6, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0); eval(); tick();

      // Saturate f2, fourth writer waits for a writeback
      for (int k = 8; k < 11; k++) begin
         drive(1, k, 0, 0, 0, 3'b000, 2, 1, 1, k, 0, 2'b00, 2'b00, 0, 0); eval(); tick();
      end
      drive(1, 11, 0, 0, 0, 3'b000, 2, 1, 1, 11, 0, 2'b00, 2'b00, 0, 0); eval();
      chk("tp_waw_stall", issue_fire_o, 1'b0);
      tick();
      drive(1, 11, 0, 0, 0, 3'b000, 2, 1, 0, 0, 0, 2'b01, 2'b01, 2, 0); eval();
      chk("tp_waw_wb_fire", issue_fire_o, 1'b1);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2, 0); eval(); tick();
      end

      // Kill then drop, and same-cycle kill
      drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 1, 7, 1, 2'b00, 2'b00, 0, 0); eval(); tick();
      drive(1, 7, 0, 0, 0, 3'b000, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0); eval();
      chk("tp_drop", drop_o, 1'b1);
      chk("tp_drop_nofire", issue_fire_o, 1'b0);
      tick();
      drive(1, 7, 0, 0, 0, 3'b000, 3, 1, 1, 7, 1, 2'b00, 2'b00, 0, 0); eval();
      chk("tp_drop_bypass", drop_o, 1'b1);
      tick();

      // Two ports retiring f4 together
      drive(1, 1, 0, 0, 0, 3'b000, 4, 1, 1, 1, 0, 2'b00, 2'b00, 0, 0); eval(); tick();
      drive(1, 2, 0, 0, 0, 3'b000, 4, 1, 1, 2, 0, 2'b00, 2'b00, 0, 0); eval(); tick();
      drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b11, 2'b11, 4, 4); eval(); tick();
      chk("tp_busy_clear", busy_o, 1'b0);
      chk("tp_no_err", err_o, 1'b0);

      // Underflow is sticky until reset
      drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b01, 2'b01, 9, 0); eval(); tick();
      chk("tp_err_set", err_o, 1'b1);
      idle(); eval(); tick();
      chk("tp_err_sticky", err_o, 1'b1);
      do_reset();

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         if (c % 100 == 99) do_reset();
         id = $urandom_range(0, NUM_IDS - 1);
         for (int p = 0; p < 2; p++) begin
            wbv[p] = 1'b0;
            wr[p]  = 0;
            if ($urandom_range(0, 2) == 0) begin
               off = $urandom_range(0, 7);
               for (int k = 0; k < 8; k++)
                  if (!wbv[p] && m_cnt[(off + k) % 8] != 0) begin
                     wbv[p] = 1'b1;
                     wr[p]  = (off + k) % 8;
                  end
            end
            wbwe[p] = ($urandom_range(0, 7) != 0);
         end
         if ($urandom_range(0, 49) == 0) begin
            wbv[0] = 1'b1;
            wr[0]  = $urandom_range(0, 7);
         end
         drive($urandom_range(0, 3) != 0, id,
               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               3'($urandom_range(0, 7)), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
               $urandom_range(0, 1) == 1,
               ($urandom_range(0, 1) == 1) ? id : int'($urandom_range(0, NUM_IDS - 1)),
               $urandom_range(0, 4) == 0, wbv, wbwe, wr[0], wr[1]);
         eval();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
